// File: rtl/ram_pkg.sv
// ram_pkg -- shared types and helpers for the ram_sdp_clr RAM family.
//   ram_clr_state_t : states of the clear sequencer (sweep / idle)
//   RDW_READ_FIRST  : same-address read-during-write returns the old word
//   RDW_WRITE_FIRST : same-address read-during-write returns the merged new word
//   BE_WIDTH()      : number of byte enables for a given data width
package ram_pkg;

    typedef enum logic {
        CLR_SWEEP = 1'b0,
        CLR_IDLE  = 1'b1
    } ram_clr_state_t;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    function automatic int BE_WIDTH(input int dwidth);
        return dwidth / 8;
    endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// ram_clr_seq -- clear sequencer for ram_sdp_clr.
// Walks an address counter over the whole array once after reset and once per
// accepted CLEAR request, asserting a write enable for every word.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset (restarts the sweep at 0)
//   clear_i    in   sweep request, only honoured while idle
//   busy_o     out  sweep in progress
//   clr_we_o   out  write-zero enable for the array
//   clr_addr_o out  address being zeroed this cycle
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int AWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [AWIDTH-1:0] clr_addr_o
);

    ram_clr_state_t    state_q, state_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            CLR_SWEEP: begin
                cnt_d = cnt_q + AWIDTH'(1);
                // the last word is written on the same cycle we leave the sweep
                if (cnt_q == {AWIDTH{1'b1}}) begin
                    state_d = CLR_IDLE;
                    busy_d  = 1'b0;
                end
            end
            CLR_IDLE: begin
                if (clear_i) begin
                    state_d = CLR_SWEEP;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = CLR_SWEEP;
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLR_SWEEP;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign clr_we_o   = busy_q;
    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/ram_sdp_clr.sv
// ram_sdp_clr -- simple-dual-port synchronous RAM with byte enables, a
// registered read port with valid flag, and a built-in zeroing sweep that runs
// after reset and on CLEAR.
// Optional build macro RAM_OUT_REG_EN: adds a second output register stage
// (read latency 2, valid pipelined with the data).
// Ports:
//   CLK    in   clock, rising edge
//   RST    in   asynchronous active-high reset
//   RDEN   in   read request          RADDR in  read address
//   RDATA  out  read data             RVALID out RDATA holds a fresh result
//   WREN   in   write request         WADDR in  write address
//   WDATA  in   write data            WBE   in  byte enables (bit i -> byte i)
//   CLEAR  in   request a full-array zero sweep
//   BUSY   out  sweep in progress, all requests ignored
module ram_sdp_clr
    import ram_pkg::*;
#(
    parameter int DWIDTH   = 16,
    parameter int AWIDTH   = 12,
    parameter int RDW_MODE = RDW_READ_FIRST
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          RDEN,
    input  logic [AWIDTH-1:0]             RADDR,
    output logic [DWIDTH-1:0]             RDATA,
    output logic                          RVALID,
    input  logic                          WREN,
    input  logic [AWIDTH-1:0]             WADDR,
    input  logic [DWIDTH-1:0]             WDATA,
    input  logic [BE_WIDTH(DWIDTH)-1:0]   WBE,
    input  logic                          CLEAR,
    output logic                          BUSY
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam int NBE   = BE_WIDTH(DWIDTH);

    generate
        if ((DWIDTH % 8) != 0) begin : g_bad_dwidth
            $error("ram_sdp_clr: DWIDTH must be a multiple of 8");
        end
    endgenerate

    logic              busy;
    logic              clr_we;
    logic [AWIDTH-1:0] clr_addr;

    ram_clr_seq #(.AWIDTH(AWIDTH)) u_clr_seq (
        .clk        (CLK),
        .rst        (RST),
        .clear_i    (CLEAR),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    // A CLEAR accepted in idle drops a concurrent write; reads still complete.
    logic user_we;
    logic rd_en;
    assign user_we = WREN && !busy && !CLEAR;
    assign rd_en   = RDEN && !busy;

    // Write port: the sweep owns the array while busy.
    logic              mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [NBE-1:0]    mem_be;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = WADDR;
        mem_wdata = WDATA;
        mem_be    = WBE;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_addr  = clr_addr;
            mem_wdata = '0;
            mem_be    = '1;
        end else if (user_we) begin
            mem_we    = 1'b1;
        end
    end

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int b = 0; b < NBE; b++) begin
                if (mem_be[b]) begin
                    mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Write-first view of the addressed word: new bytes where enabled.
    logic [DWIDTH-1:0] rd_word;
    logic [DWIDTH-1:0] wr_merged;
    assign rd_word = mem[RADDR];

    genvar gi;
    generate
        for (gi = 0; gi < NBE; gi++) begin : g_merge
            assign wr_merged[8*gi +: 8] = WBE[gi] ? WDATA[8*gi +: 8] : rd_word[8*gi +: 8];
        end
    endgenerate

    logic bypass;
    assign bypass = (RDW_MODE == RDW_WRITE_FIRST) && user_we && (WADDR == RADDR);

    // Stage 1 read register: data holds when no read is accepted.
    logic [DWIDTH-1:0] rdata1_q, rdata1_d;
    logic              rvalid1_q, rvalid1_d;

    always_comb begin
        rdata1_d  = rdata1_q;
        rvalid1_d = rd_en;
        if (rd_en) begin
            rdata1_d = bypass ? wr_merged : rd_word;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata1_q  <= '0;
            rvalid1_q <= 1'b0;
        end else begin
            rdata1_q  <= rdata1_d;
            rvalid1_q <= rvalid1_d;
        end
    end

`ifdef RAM_OUT_REG_EN
    // Stage 2: data advances only with a valid stage-1 result.
    logic [DWIDTH-1:0] rdata2_q, rdata2_d;
    logic              rvalid2_q, rvalid2_d;

    always_comb begin
        rdata2_d  = rvalid1_q ? rdata1_q : rdata2_q;
        rvalid2_d = rvalid1_q && !busy;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata2_q  <= '0;
            rvalid2_q <= 1'b0;
        end else begin
            rdata2_q  <= rdata2_d;
            rvalid2_q <= rvalid2_d;
        end
    end

    assign RDATA  = rdata2_q;
    assign RVALID = rvalid2_q;
`else
    assign RDATA  = rdata1_q;
    assign RVALID = rvalid1_q;
`endif

    assign BUSY = busy;

endmodule

// File: doc/ram_sdp_clr.md
Name: ram_sdp_clr

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port with byte enables, one read port with a registered output and a valid flag.
- Built-in clear sequencer zeroes the whole array after reset and on request.
- Generalises the single-port 16x4096 RAM in width, depth, port count, read-during-write mode and initialisation.
- Sits under FIFOs, line buffers and coefficient stores.

Parameters:
- DWIDTH, 16, data width in bits; must be a multiple of 8 (elaboration error otherwise).
- AWIDTH, 12, address width; DEPTH = 2**AWIDTH words.
- RDW_MODE, 0, same-address read-during-write result: 0 = read-first (old data), 1 = write-first (merged new data).

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- RDEN  in  1  read request.
- RADDR  in  AWIDTH  read address.
- RDATA  out  DWIDTH  read data.
- RVALID  out  1  RDATA carries the result of a read accepted last cycle.
- WREN  in  1  write request.
- WADDR  in  AWIDTH  write address.
- WDATA  in  DWIDTH  write data.
- WBE  in  DWIDTH/8  byte enables; bit i controls WDATA[8i+7:8i].
- CLEAR  in  1  request a full-array zero sweep.
- BUSY  out  1  clear sweep in progress; ports ignored.

Behaviour:
- One clock (CLK); reset RST is asynchronous and active-high.
- Reset values: RDATA = 0, RVALID = 0, BUSY = 1, FSM = SWEEP, sweep counter = 0. The array itself is not reset asynchronously.
- FSM state SWEEP:
  - Each cycle writes 0 to mem[cnt], then cnt <= cnt+1.
  - On the cycle cnt == DEPTH-1 it writes the last word and moves to IDLE.
  - The sweep takes exactly DEPTH cycles after RST deasserts; BUSY = 1 throughout, 0 in IDLE.
- FSM state IDLE: CLEAR = 1 -> SWEEP next cycle with cnt = 0; BUSY rises that next cycle.
- While BUSY: RDEN, WREN and CLEAR are ignored; RVALID = 0; RDATA holds its last value.
- Read: RDEN = 1 sampled at edge n in IDLE -> after edge n, RDATA = mem[RADDR] and RVALID = 1 (latency 1).
- Read with RDEN = 0: RVALID = 0 next cycle; RDATA holds.
- Write: WREN = 1 in IDLE -> after the edge, byte i of mem[WADDR] = WDATA byte i where WBE[i] = 1; other bytes unchanged. WBE = 0 is a no-op.
- Read and write same cycle, different addresses: both complete independently.
- Same address, RDW_MODE 0: RDATA = pre-write word.
- Same address, RDW_MODE 1: RDATA = post-write merged word.
- CLEAR with WREN/RDEN in the same IDLE cycle: CLEAR wins; the write is dropped and the read still completes (RVALID = 1 next cycle, old data).
- RST asserted mid-sweep: sweep restarts from 0. RST mid-read: RVALID = 0 immediately.
- Addresses cover the full 2**AWIDTH range, so no out-of-range case exists.

Optional Feature:
- Macro RAM_OUT_REG_EN.
- Defined: adds a second output register stage. Read latency = 2; RVALID is pipelined alongside the data; both stages reset to 0; the RDW result is fixed at stage 1. BUSY forces both stage valids to 0.
- Undefined: latency 1 as above.

Decomposition:
- Package ram_pkg:
  - enum typedef ram_clr_state_t {CLR_SWEEP, CLR_IDLE}.
  - constants RDW_READ_FIRST = 0, RDW_WRITE_FIRST = 1.
  - function BE_WIDTH(DWIDTH) = DWIDTH/8.
- One sub-module, ram_clr_seq: FSM plus AWIDTH counter. Outputs BUSY, clear write enable and clear address, which the top muxes onto the write port.

Test Plan:
- Reset, then hold RST low: BUSY = 1 for exactly 4096 cycles (defaults), then 0. Reading addresses 0, 2047, 4095 returns 0x0000 with RVALID = 1 one cycle later.
- Write 0xBEEF @ 0x010 with WBE = 2'b11, then WBE = 2'b01 data 0x1234 -> read @ 0x010 returns 0xBE34.
- Same-cycle write 0xAAAA / read @ 0x020 holding 0x5555: RDW_MODE 0 -> 0x5555; RDW_MODE 1 -> 0xAAAA.
- Pulse CLEAR in IDLE with WREN = 1: write lost, BUSY = 1 next cycle for 4096 cycles; RDEN during the sweep gives RVALID = 0; afterwards previously written words read 0.
- Assert RST at sweep count 100: RDATA = 0 and RVALID = 0 immediately; full 4096-cycle sweep repeats.
- With RAM_OUT_REG_EN, DWIDTH = 32, AWIDTH = 4: back-to-back reads @ 1,2,3 -> RVALID high on cycles +2..+4 with data in order; BUSY lasts 16 cycles.
